// File: rtl/fp8_pkg.sv
// fp8_pkg: shared definitions for the FP8 add arbiter.
//   - FSM state encoding for the arbiter controller
//   - FP8 field layout {sign[7], exp[6:3], mant[2:0]}. There is no implicit
//     bit and there are no special values.
//   - Exponent ceiling and the saturated result pattern
//   - Small field-extraction helpers used by the arithmetic core
package fp8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } fp8_state_e;

    localparam int FP8_W        = 8;
    localparam int FP8_SIGN_POS = 7;
    localparam int FP8_EXP_LSB  = 3;
    localparam int FP8_EXP_W    = 4;
    localparam int FP8_MANT_LSB = 0;
    localparam int FP8_MANT_W   = 3;
    localparam int FP8_EXP_MAX  = 15;

    // Saturated magnitude: exp = 15, mant = 0. The sign is attached by fp8_sat.
    localparam logic [6:0] FP8_SAT_MAG = 7'h78;

    function automatic logic fp8_sign(input logic [FP8_W-1:0] x);
        return x[FP8_SIGN_POS];
    endfunction

    function automatic logic [FP8_EXP_W-1:0] fp8_exp(input logic [FP8_W-1:0] x);
        return x[FP8_EXP_LSB +: FP8_EXP_W];
    endfunction

    function automatic logic [FP8_MANT_W-1:0] fp8_mant(input logic [FP8_W-1:0] x);
        return x[FP8_MANT_LSB +: FP8_MANT_W];
    endfunction

    function automatic logic [FP8_W-1:0] fp8_sat(input logic sign);
        return {sign, FP8_SAT_MAG};
    endfunction

endpackage

// File: rtl/fp8_add_core.sv
// fp8_add_core: purely combinational FP8 adder.
//   a   (in,  8) : operand A
//   b   (in,  8) : operand B
//   sum (out, 8) : A + B. The mantissa is truncated, an exponent overflow
//                  saturates, and a subtraction result is never normalised.
module fp8_add_core
    import fp8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic                  a_larger_s;
    logic [7:0]            op_l_s;
    logic [7:0]            op_s_s;
    logic [FP8_EXP_W-1:0]  exp_l_s;
    logic [FP8_EXP_W-1:0]  exp_diff_s;
    logic [FP8_MANT_W-1:0] mant_sh_s;
    logic [3:0]            mant_sum_s;
    logic [4:0]            exp_inc_s;
    logic                  sign_l_s;

    // Align the smaller operand, add or subtract the mantissas, then renormalise on carry.
    always_comb begin
        // {exp, mant} occupy bits [6:0] contiguously, so one magnitude compare
        // orders the operands by exp first and mant second. A full tie selects B.
        a_larger_s = (a[6:0] > b[6:0]);
        if (a_larger_s) begin
            op_l_s = a;
            op_s_s = b;
        end else begin
            op_l_s = b;
            op_s_s = a;
        end

        exp_l_s    = fp8_exp(op_l_s);
        sign_l_s   = fp8_sign(op_l_s);
        exp_diff_s = exp_l_s - fp8_exp(op_s_s);

        if (exp_diff_s >= 4'd3) begin
            mant_sh_s = 3'd0;
        end else begin
            mant_sh_s = fp8_mant(op_s_s) >> exp_diff_s;
        end

        // Only 4 bits are kept. A subtraction that underflows wraps modulo 16.
        if (fp8_sign(op_l_s) == fp8_sign(op_s_s)) begin
            mant_sum_s = {1'b0, fp8_mant(op_l_s)} + {1'b0, mant_sh_s};
        end else begin
            mant_sum_s = {1'b0, fp8_mant(op_l_s)} - {1'b0, mant_sh_s};
        end

        exp_inc_s = {1'b0, exp_l_s} + 5'd1;

        if (!mant_sum_s[3]) begin
            sum = {sign_l_s, exp_l_s, mant_sum_s[2:0]};
        end else if (exp_inc_s > 5'(FP8_EXP_MAX)) begin
            sum = fp8_sat(sign_l_s);
        end else begin
            sum = {sign_l_s, exp_inc_s[3:0], mant_sum_s[3:1]};
        end
    end

endmodule

// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter: round-robin arbiter in front of a shared FP8 adder.
//   clk        (in)         : rising-edge clock
//   rst_n      (in)         : asynchronous active-low reset
//   req_valid  (in,  NREQ)  : per-requester operation request
//   req_ready  (out, NREQ)  : one-hot accept, high only in IDLE
//   req_a/b    (in,  8*NREQ): operands, requester i at [8*i+7:8*i]
//   rsp_valid  (out)        : result is available, held until rsp_ready
//   rsp_ready  (in)         : consumer accepts the result
//   rsp_data   (out, 8)     : FP8 sum
//   rsp_id     (out, ID_W)  : requester that owns the result
//   busy       (out)        : FSM is not in IDLE
// Timing: a request accepted in cycle T gives rsp_valid from cycle T+2.
// At most one operation completes every 3 cycles.
module fp8_add_arbiter
    import fp8_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*8-1:0]  req_a,
    input  logic [NREQ*8-1:0]  req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    output logic               busy
);

    fp8_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        a_q, b_q;
    logic [7:0]        rsp_data_q;
    logic              grant_valid_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [7:0]        a_sel_s, b_sel_s;
    logic [7:0]        sum_s;
    logic [2:0]        pos_s;

    // Round-robin search from rr_ptr. Descending k lets the nearest valid requester win.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        pos_s         = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos_s = 3'(rr_ptr_q) + 3'(k);
            if (pos_s >= 3'(NREQ)) begin
                pos_s = pos_s - 3'(NREQ);
            end else begin
                pos_s = pos_s;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (pos_s == 3'(i))) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = ID_W'(i);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Operand mux for the granted requester, and the pointer that follows it.
    always_comb begin
        a_sel_s = 8'h00;
        b_sel_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == ID_W'(i)) begin
                a_sel_s = req_a[8*i +: 8];
                b_sel_s = req_b[8*i +: 8];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
        if (grant_idx_s == ID_W'(NREQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx_s + ID_W'(1);
        end
    end

    fp8_add_core u_core (
        .a   (a_q),
        .b   (b_q),
        .sum (sum_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) state_d = ST_EXEC;
                else               state_d = ST_IDLE;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
                else           state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. rst_n gates req_ready so that no accept is shown while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state_q == ST_IDLE) && grant_valid_s
                           && (grant_idx_s == ID_W'(i));
        end
        busy      = (state_q != ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    // Datapath: capture on accept, register the sum in EXEC, hold through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            id_q       <= '0;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            rsp_data_q <= 8'h00;
        end else if ((state_q == ST_IDLE) && grant_valid_s) begin
            rr_ptr_q <= rr_ptr_d;
            id_q     <= grant_idx_s;
            a_q      <= a_sel_s;
            b_q      <= b_sel_s;
        end else if (state_q == ST_EXEC) begin
            rsp_data_q <= sum_s;
        end else begin
            rsp_data_q <= rsp_data_q;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = id_q;

endmodule

// File: doc/fp8_add_arbiter.md
FP8_ADD_ARBITER -- requirements
Module: fp8_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning the number of requesters; legal range is 2..4.
REQ-002 SHALL have parameter ID_W, default 2, meaning the width of rsp_id; it is fixed at 2 for all NREQ.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NREQ bits: per-requester accept; at most one bit is high.
REQ-007 SHALL have port req_a, input, NREQ*8 bits: operand A of requester i at [8*i+7:8*i].
REQ-008 SHALL have port req_b, input, NREQ*8 bits: operand B of requester i, packed the same way.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port rsp_data, output, 8 bits: the FP8 sum.
REQ-012 SHALL have port rsp_id, output, ID_W bits: the index of the requester that owns the result.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL use FP8 format {sign[7], exp[6:3], mant[2:0]}, with no implicit bit and no special values.
REQ-015 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-016 SHALL, in IDLE, grant round-robin starting at pointer rr_ptr: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-017 SHALL, in IDLE with any req_valid high, assert req_ready only for the granted index (combinational).
REQ-018 SHALL, on that cycle, capture the operands and the ID, set rr_ptr to (grant+1) mod NREQ, and go to EXEC.
REQ-019 SHALL hold req_ready at all zeros outside IDLE.
REQ-020 SHALL allow req_valid to drop before it is accepted; nothing is queued.
REQ-021 SHALL, in EXEC, register the adder result into rsp_data and go to RESP.
REQ-022 SHALL, in RESP, hold rsp_valid=1 with rsp_data and rsp_id stable until rsp_ready=1, then go to IDLE.
REQ-023 SHALL give a latency of request accept at cycle T, rsp_valid=1 from cycle T+2, and at most one operation per 3 cycles.
REQ-024 SHALL select the larger operand as the one with the greater exp; on equal exp, the greater mant; on full tie, operand B.
REQ-025 SHALL right-shift the smaller operand's mant by the exp difference; a shift of 3 or more gives 0.
REQ-026 SHALL form a 4-bit sum: mant_L+mant_S if the signs are equal, else mant_L-mant_S; result sign = sign of the larger operand.
REQ-027 SHALL, if sum[3]=0, produce exp=exp_L and mant=sum[2:0].
REQ-028 SHALL, if sum[3]=1, produce exp=exp_L+1 and mant=sum[3:1], truncated.
REQ-029 SHALL, if exp_L+1 would exceed 15, saturate to exp=15, mant=0, keeping the sign.
REQ-030 SHALL NOT normalise results of subtraction.

Reset
REQ-031 SHALL, with rst_n low, drive immediately: state IDLE, rr_ptr 0, rsp_valid 0, rsp_data 0x00, rsp_id 0, busy 0, req_ready 0.
REQ-032 SHALL abort an in-flight operation on reset with no response produced, and resume normal function on the first clock edge after rst_n rises.

Structure
REQ-033 SHALL have package fp8_pkg hold: the FSM state enum, field positions/widths of the FP8 format, FP8_EXP_MAX=15, and the saturated pattern.
REQ-034 SHALL put the arithmetic of REQ-024..REQ-030 in the purely combinational sub-module fp8_add_core (a, b in; sum out), instantiated once.

Verification
REQ-035 SHALL cover: req0 with a=0x38, b=0x39 -> rsp_data 0x39, rsp_id 0, rsp_valid 2 cycles after accept.
REQ-036 SHALL cover: a=0x3F, b=0x3F -> 0x47 (carry); a=0x7F, b=0x7F -> 0x78 (saturation).
REQ-037 SHALL cover: a=0x3D, b=0xBA -> 0x3B (subtract); a=0x4C, b=0x3C -> 0x4D (shift by 2).
REQ-038 SHALL cover: req0 and req1 both held valid after reset -> grants in the order 0,1,0,1 and rsp_id matches each grant.
REQ-039 SHALL cover: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, req_ready all 0.
REQ-040 SHALL cover: rst_n pulsed low during EXEC -> outputs at reset values immediately, and no response issued afterwards.
